// File: rtl/alu_issue_stage.sv
// Purpose: ID/EX issue stage; decodes ALUOp/funct into ALU control and buffers up to 2 ops.
// Latency: an op accepted at edge N is presented at the outputs after edge N (no bypass).
// Backpressure: in_ready drops when both entries are held; head stays stable until out_ready.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic             alu_src,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [4:0]       rd_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  Rd1,
  output logic [XLEN-1:0]  Rd2_or_Imm,
  output logic [3:0]       control_in,
  output logic [4:0]       rd_out,
  output logic             illegal,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] issue_count
);

  typedef struct packed {
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [3:0]      ctrl;
    logic            ill;
    logic [4:0]      rd;
  } entry_t;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  entry_t           mem [2];
  entry_t           new_entry;
  entry_t           head;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_ctrl;
  logic             dec_ill;
  logic             accept;
  logic             issue;

  // Decode ALUOp/funct into the ALU control code; anything unsupported flags illegal.
  always_comb begin
    dec_ctrl = CTRL_BAD;
    dec_ill  = 1'b1;
    unique case (alu_op)
      2'b00: begin dec_ctrl = CTRL_ADD; dec_ill = 1'b0; end
      2'b01: begin dec_ctrl = CTRL_SUB; dec_ill = 1'b0; end
      2'b10: begin
        case (funct3)
          3'b000:  begin dec_ctrl = funct7_5 ? CTRL_SUB : CTRL_ADD; dec_ill = 1'b0; end
          3'b111:  begin dec_ctrl = CTRL_AND; dec_ill = 1'b0; end
          3'b110:  begin dec_ctrl = CTRL_OR;  dec_ill = 1'b0; end
          default: begin dec_ctrl = CTRL_BAD; dec_ill = 1'b1; end
        endcase
      end
      default: begin
        // I-type: funct7_5 is part of the immediate, so it never selects subtract
        case (funct3)
          3'b000:  begin dec_ctrl = CTRL_ADD; dec_ill = 1'b0; end
          3'b111:  begin dec_ctrl = CTRL_AND; dec_ill = 1'b0; end
          3'b110:  begin dec_ctrl = CTRL_OR;  dec_ill = 1'b0; end
          default: begin dec_ctrl = CTRL_BAD; dec_ill = 1'b1; end
        endcase
      end
    endcase
  end

  assign new_entry.opa  = rs1_data;
  assign new_entry.opb  = alu_src ? imm : rs2_data;
  assign new_entry.ctrl = dec_ctrl;
  assign new_entry.ill  = dec_ill;
  assign new_entry.rd   = rd_addr;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign accept    = in_valid & in_ready & ~flush;
  assign issue     = out_valid & out_ready;

  // Entry storage; contents only matter while counted in occ, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointers, occupancy and issue counter; flush still lets a same-cycle issue count.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (issue) begin
        cnt <= cnt + 1'b1;
      end
      if (flush) begin
        occ    <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (accept) wr_ptr <= ~wr_ptr;
        if (issue)  rd_ptr <= ~rd_ptr;
        occ <= occ + {1'b0, accept} - {1'b0, issue};
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign Rd1         = out_valid ? head.opa  : '0;
  assign Rd2_or_Imm  = out_valid ? head.opb  : '0;
  assign control_in  = out_valid ? head.ctrl : CTRL_BAD;
  assign illegal     = out_valid ? head.ill  : 1'b0;
  assign rd_out      = out_valid ? head.rd   : 5'd0;
  assign occupancy   = occ;
  assign issue_count = cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Purpose: scoreboard bench for alu_issue_stage against a queue-based reference model.
// Latency: model pushes at accept edge, monitor compares head at every negedge.
// Backpressure: random out_ready stalls exercise the full/hold behaviour.
module tb_alu_issue_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready;
  logic [XLEN-1:0]  rs1_data, rs2_data, imm;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic [4:0]       rd_addr;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  Rd1, Rd2_or_Imm;
  logic [3:0]       control_in;
  logic [4:0]       rd_out;
  logic             illegal;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] issue_count;

  alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready), .Rd1(Rd1), .Rd2_or_Imm(Rd2_or_Imm),
    .control_in(control_in), .rd_out(rd_out), .illegal(illegal),
    .occupancy(occupancy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic        il;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int   exp_cnt   = 0;
  int   occ_seen  = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  bit   mon_en    = 0;

  // Reference decode written straight from the operation table.
  function automatic void ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                     input logic f7, output logic [3:0] c, output logic il);
    c = 4'b1111; il = 1'b1;
    if (op == 2'b00) begin c = 4'b0010; il = 1'b0; end
    else if (op == 2'b01) begin c = 4'b0110; il = 1'b0; end
    else if (f3 == 3'b111) begin c = 4'b0000; il = 1'b0; end
    else if (f3 == 3'b110) begin c = 4'b0001; il = 1'b0; end
    else if (f3 == 3'b000) begin
      il = 1'b0;
      c  = (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the active edge: reset, flush, then accept of a new operation.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      exp_cnt = 0;
    end else if (flush) begin
      q.delete();
    end else if (in_valid && occ_seen < 2) begin
      exp_t e;
      e.a  = rs1_data;
      e.b  = alu_src ? imm : rs2_data;
      e.rd = rd_addr;
      ref_decode(alu_op, funct3, funct7_5, e.c, e.il);
      q.push_back(e);
    end
  end

  // Monitor: compare status every cycle, compare and retire the head on a handshake.
  always @(negedge clk) begin
    occ_seen = q.size();
    if (mon_en) begin
      chk("occupancy", occupancy, q.size());
      chk("in_ready", in_ready, q.size() != 2);
      chk("out_valid", out_valid, q.size() != 0);
      chk("issue_count", issue_count, exp_cnt % 16);
      if (q.size() == 0) begin
        chk("empty_ctrl", control_in, 4'b1111);
        chk("empty_illegal", illegal, 1'b0);
        chk("empty_rd1", Rd1, 0);
        chk("empty_opb", Rd2_or_Imm, 0);
        chk("empty_rd", rd_out, 0);
      end else begin
        chk("head_rd1", Rd1, q[0].a);
        chk("head_opb", Rd2_or_Imm, q[0].b);
        chk("head_ctrl", control_in, q[0].c);
        chk("head_illegal", illegal, q[0].il);
        chk("head_rd", rd_out, q[0].rd);
        if (out_ready) begin
          void'(q.pop_front());
          exp_cnt++;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                    input logic src, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] im, input logic [4:0] rd);
    in_valid = 1'b1; alu_op = aop; funct3 = f3; funct7_5 = f7; alu_src = src;
    rs1_data = a; rs2_data = b; imm = im; rd_addr = rd;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rs1_data = '0; rs2_data = '0; imm = '0; alu_src = 1'b0;
    alu_op = '0; funct3 = '0; funct7_5 = 1'b0; rd_addr = '0;
    tick(2);
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Add, subtract, immediate OR
    op(2'b10, 3'b000, 1'b0, 1'b0, 10, 5, 0, 5'd3);
    op(2'b10, 3'b000, 1'b1, 1'b0, 20, 20, 0, 5'd4);
    op(2'b11, 3'b110, 1'b0, 1'b1, 1, 7, 32'hF0F0F0F0, 5'd5);
    tick(2);
    chk("count_after_3", issue_count, 3);

    // Backpressure: fill, attempt third push, then drain
    out_ready = 1'b0;
    op(2'b00, 3'b000, 1'b0, 1'b0, 1, 1, 0, 5'd1);
    op(2'b01, 3'b000, 1'b0, 1'b0, 2, 2, 0, 5'd2);
    op(2'b10, 3'b111, 1'b0, 1'b0, 3, 3, 0, 5'd9);
    chk("full_rd_out", rd_out, 5'd1);
    out_ready = 1'b1;
    tick(3);
    chk("count_after_drain", issue_count, 5);

    // Illegal and I-type funct7_5 ignored
    op(2'b10, 3'b001, 1'b0, 1'b0, 4, 4, 0, 5'd6);
    op(2'b11, 3'b000, 1'b1, 1'b0, 4, 4, 0, 5'd7);
    tick(2);

    // Flush with full buffer and a competing push
    out_ready = 1'b0;
    op(2'b00, 3'b000, 1'b0, 1'b0, 8, 8, 0, 5'd8);
    op(2'b00, 3'b000, 1'b0, 1'b0, 9, 9, 0, 5'd9);
    flush = 1'b1;
    op(2'b00, 3'b000, 1'b0, 1'b0, 10, 10, 0, 5'd10);
    flush = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_count", issue_count, 7);

    // Reset with one held entry
    op(2'b00, 3'b000, 1'b0, 1'b0, 11, 11, 0, 5'd11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_count", issue_count, 0);
    chk("reset_ctrl", control_in, 4'b1111);
    out_ready = 1'b1;

    // Counter wrap: 17 issues on a 4-bit counter
    for (int i = 0; i < 17; i++) op(2'b00, 3'b000, 1'b0, 1'b0, i, i, 0, 5'(i));
    tick(2);
    chk("wrap_count", issue_count, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      alu_op    = 2'($urandom);
      funct3    = 3'($urandom);
      funct7_5  = 1'($urandom);
      alu_src   = 1'($urandom);
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      imm       = $urandom;
      rd_addr   = 5'($urandom);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(3);
    chk("final_empty", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
